// File: rtl/fifo_burst_read_requester_if.sv
// ---------------------------------------------------------------------------
// fifo_burst_read_requester_if
// Bundles the control, memory-request and FIFO-write signals of the burst
// read requester.
//   master : the requester (drives busy/done, memory request, FIFO write)
//   slave  : the environment (control inputs, memory data, FIFO almost_full)
// Signals:
//   start_i, abort_i, base_addr_i, len_i  burst control
//   busy_o, done_o                        burst status
//   mem_rd_en_o, mem_addr_o, mem_rdata_i  fixed-latency memory read port
//   fifo_almost_full_i, fifo_wren_o,
//   fifo_wdata_o                          downstream FIFO write port
// ---------------------------------------------------------------------------
interface fifo_burst_read_requester_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
);
    logic                  start_i;
    logic                  abort_i;
    logic [ADDR_WIDTH-1:0] base_addr_i;
    logic [LEN_WIDTH-1:0]  len_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  mem_rd_en_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;
    logic                  fifo_almost_full_i;
    logic                  fifo_wren_o;
    logic [DATA_WIDTH-1:0] fifo_wdata_o;

    modport master (
        input  start_i, abort_i, base_addr_i, len_i, mem_rdata_i, fifo_almost_full_i,
        output busy_o, done_o, mem_rd_en_o, mem_addr_o, fifo_wren_o, fifo_wdata_o
    );

    modport slave (
        output start_i, abort_i, base_addr_i, len_i, mem_rdata_i, fifo_almost_full_i,
        input  busy_o, done_o, mem_rd_en_o, mem_addr_o, fifo_wren_o, fifo_wdata_o
    );
endinterface

// File: rtl/fifo_burst_read_requester.sv
// ---------------------------------------------------------------------------
// fifo_burst_read_requester
// Issues LEN single-word reads to a fixed-latency memory starting at a base
// address and writes every returned word into a downstream FIFO in request
// order. New requests are throttled by the FIFO almost_full flag and by a
// credit counter of requests in flight, so the FIFO cannot overflow even if
// its consumer stalls indefinitely.
// Ports:
//   clk      clock
//   reset_n  asynchronous active-low reset
//   bus      fifo_burst_read_requester_if.master (control, status, memory
//            read port, FIFO write port)
// ---------------------------------------------------------------------------
module fifo_burst_read_requester #(
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 32,
    parameter int LEN_WIDTH       = 16,
    parameter int RD_LATENCY      = 2,
    parameter int MAX_OUTSTANDING = 2,
    parameter int OUTST_WIDTH     = 2
) (
    input  logic                           clk,
    input  logic                           reset_n,
    fifo_burst_read_requester_if.master    bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [OUTST_WIDTH-1:0] OUTST_ZERO_C = {OUTST_WIDTH{1'b0}};
    localparam logic [OUTST_WIDTH-1:0] OUTST_ONE_C  = OUTST_WIDTH'(1);
    localparam logic [OUTST_WIDTH-1:0] OUTST_MAX_C  = OUTST_WIDTH'(MAX_OUTSTANDING);
    localparam logic [LEN_WIDTH-1:0]   LEN_ZERO_C   = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0]   LEN_ONE_C    = LEN_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0]  ADDR_ZERO_C  = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE_C   = ADDR_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0]  DATA_ZERO_C  = {DATA_WIDTH{1'b0}};
    localparam logic [RD_LATENCY-1:0]  LAT_ZERO_C   = {RD_LATENCY{1'b0}};

    state_t                 state_r;
    logic [ADDR_WIDTH-1:0]  addr_r;
    logic [LEN_WIDTH-1:0]   remaining_r;
    logic [OUTST_WIDTH-1:0] outstanding_r;
    logic [RD_LATENCY-1:0]  lat_sr_r;

    logic                   issue_s;
    logic                   drain_empty_s;
    logic [OUTST_WIDTH-1:0] outstanding_next_s;
    logic [RD_LATENCY-1:0]  lat_next_s;
    logic [DATA_WIDTH-1:0]  rdata_s;

    assign rdata_s = bus.mem_rdata_i;

    // Request issue decision: abort wins over issue in the same cycle.
    always_comb begin
        issue_s = 1'b0;
        if ((state_r == ST_RUN) && !bus.abort_i && (remaining_r != LEN_ZERO_C) &&
            !bus.fifo_almost_full_i && (outstanding_r < OUTST_MAX_C)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Credit counter next value: +1 per issue, -1 per FIFO write, hold when both.
    always_comb begin
        outstanding_next_s = outstanding_r;
        case ({issue_s, bus.fifo_wren_o})
            2'b10: outstanding_next_s = outstanding_r + OUTST_ONE_C;
            2'b01: begin
                if (outstanding_r != OUTST_ZERO_C) begin
                    outstanding_next_s = outstanding_r - OUTST_ONE_C;
                end else begin
                    outstanding_next_s = outstanding_r;
                end
            end
            default: outstanding_next_s = outstanding_r;
        endcase
    end

    // Latency tracker: fed by the registered request strobe so its tail lines
    // up with the cycle in which mem_rdata_i carries that request's data.
    always_comb begin
        lat_next_s    = LAT_ZERO_C;
        lat_next_s[0] = bus.mem_rd_en_o;
        for (int i = 1; i < RD_LATENCY; i++) begin
            lat_next_s[i] = lat_sr_r[i-1];
        end
    end

    // Drain completes once every request has been written to the FIFO.
    always_comb begin
        drain_empty_s = 1'b0;
        if ((outstanding_r == OUTST_ZERO_C) && (lat_sr_r == LAT_ZERO_C)) begin
            drain_empty_s = 1'b1;
        end else begin
            drain_empty_s = 1'b0;
        end
    end

    // Burst FSM with registered request, FIFO-write and status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r          <= ST_IDLE;
            addr_r           <= ADDR_ZERO_C;
            remaining_r      <= LEN_ZERO_C;
            outstanding_r    <= OUTST_ZERO_C;
            lat_sr_r         <= LAT_ZERO_C;
            bus.busy_o       <= 1'b0;
            bus.done_o       <= 1'b0;
            bus.mem_rd_en_o  <= 1'b0;
            bus.mem_addr_o   <= ADDR_ZERO_C;
            bus.fifo_wren_o  <= 1'b0;
            bus.fifo_wdata_o <= DATA_ZERO_C;
        end else begin
            bus.mem_rd_en_o <= issue_s;
            if (issue_s) begin
                bus.mem_addr_o <= addr_r;
            end
            lat_sr_r        <= lat_next_s;
            bus.fifo_wren_o <= lat_sr_r[RD_LATENCY-1];
            if (lat_sr_r[RD_LATENCY-1]) begin
                bus.fifo_wdata_o <= rdata_s;
            end
            outstanding_r <= outstanding_next_s;
            bus.done_o    <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        addr_r      <= bus.base_addr_i;
                        remaining_r <= bus.len_i;
                        bus.busy_o  <= 1'b1;
                        if (bus.len_i == LEN_ZERO_C) begin
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end else begin
                        bus.busy_o <= 1'b0;
                    end
                end
                ST_RUN: begin
                    bus.busy_o <= 1'b1;
                    if (bus.abort_i) begin
                        state_r <= ST_DRAIN;
                    end else if (issue_s) begin
                        addr_r      <= addr_r + ADDR_ONE_C;
                        remaining_r <= remaining_r - LEN_ONE_C;
                        if (remaining_r == LEN_ONE_C) begin
                            state_r <= ST_DRAIN;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    bus.busy_o <= 1'b1;
                    if (drain_empty_s) begin
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    bus.done_o <= 1'b1;
                    bus.busy_o <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    bus.busy_o <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_read_requester.sv
// ---------------------------------------------------------------------------
// tb_fifo_burst_read_requester
// Directed bench: a fixed-latency memory returning data = address, a depth-4
// FIFO with a switchable consumer, and a monitor collecting request
// addresses, FIFO write data and done pulses for comparison against
// hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_fifo_burst_read_requester;

    localparam int AW         = 16;
    localparam int DW         = 32;
    localparam int LW         = 16;
    localparam int RD_LAT     = 2;
    localparam int MAX_OUT    = 2;
    localparam int FIFO_DEPTH = 4;

    logic clk;
    logic reset_n;
    logic consumer_en;

    fifo_burst_read_requester_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    fifo_burst_read_requester #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW),
        .RD_LATENCY(RD_LAT), .MAX_OUTSTANDING(MAX_OUT), .OUTST_WIDTH(2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] addr_q[$];
    logic [31:0] wdata_q[$];
    int done_cnt     = 0;
    int inflight     = 0;
    int max_inflight = 0;
    int fifo_count   = 0;
    int overflow_cnt = 0;

    logic [AW-1:0] mem_pipe_a [RD_LAT];
    logic          mem_pipe_v [RD_LAT];

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Fixed-latency memory: data = zero-extended address, garbage when idle.
    always @(posedge clk) begin
        mem_pipe_a[0] <= bus.mem_addr_o;
        mem_pipe_v[0] <= bus.mem_rd_en_o;
        for (int i = 1; i < RD_LAT; i++) begin
            mem_pipe_a[i] <= mem_pipe_a[i-1];
            mem_pipe_v[i] <= mem_pipe_v[i-1];
        end
    end
    assign bus.mem_rdata_i = (mem_pipe_v[RD_LAT-1] === 1'b1) ?
                             {16'h0000, mem_pipe_a[RD_LAT-1]} : 32'hDEAD_BEEF;

    // FIFO occupancy model with switchable consumer.
    always @(posedge clk) begin
        if (bus.fifo_wren_o && (fifo_count >= FIFO_DEPTH)) begin
            overflow_cnt <= overflow_cnt + 1;
        end
        fifo_count <= fifo_count
                    + (((bus.fifo_wren_o === 1'b1) && (fifo_count < FIFO_DEPTH)) ? 1 : 0)
                    - ((consumer_en && (fifo_count > 0)) ? 1 : 0);
    end
    assign bus.fifo_almost_full_i = (fifo_count > (FIFO_DEPTH - MAX_OUT));

    // Monitor: request addresses, FIFO writes, done pulses, requests in flight.
    always @(negedge clk) begin
        if (!reset_n) begin
            inflight <= 0;
        end else begin
            if (bus.mem_rd_en_o === 1'b1) addr_q.push_back({16'h0000, bus.mem_addr_o});
            if (bus.fifo_wren_o === 1'b1) wdata_q.push_back(bus.fifo_wdata_o);
            if (bus.done_o === 1'b1) done_cnt <= done_cnt + 1;
            inflight <= inflight + ((bus.mem_rd_en_o === 1'b1) ? 1 : 0)
                                 - ((bus.fifo_wren_o === 1'b1) ? 1 : 0);
            if (inflight > max_inflight) max_inflight <= inflight;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_burst(input logic [15:0] base, input logic [15:0] len);
        bus.base_addr_i = base;
        bus.len_i       = len;
        bus.start_i     = 1'b1;
        @(negedge clk);
        bus.start_i     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int n;
        n = 0;
        while ((bus.done_o !== 1'b1) && (n < max_cyc)) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(bus.done_o), 32'd1);
    endtask

    task automatic wait_rd_pulses(input string tag, input int k, input int max_cyc);
        int n;
        int cnt;
        n   = 0;
        cnt = 0;
        while ((cnt < k) && (n < max_cyc)) begin
            @(negedge clk);
            n++;
            if (bus.mem_rd_en_o === 1'b1) cnt++;
        end
        check_eq(tag, 32'(cnt), 32'(k));
    endtask

    task automatic clear_logs();
        addr_q.delete();
        wdata_q.delete();
    endtask

    // Directed test sequence.
    initial begin
        int d0;
        int na;
        int nw;
        reset_n         = 1'b1;
        consumer_en     = 1'b1;
        bus.start_i     = 1'b0;
        bus.abort_i     = 1'b0;
        bus.base_addr_i = 16'h0000;
        bus.len_i       = 16'h0000;
        #2 reset_n = 1'b0;
        tick(3);
        check_eq("rst_busy",  32'(bus.busy_o),       32'd0);
        check_eq("rst_done",  32'(bus.done_o),       32'd0);
        check_eq("rst_rd_en", 32'(bus.mem_rd_en_o),  32'd0);
        check_eq("rst_addr",  32'(bus.mem_addr_o),   32'd0);
        check_eq("rst_wren",  32'(bus.fifo_wren_o),  32'd0);
        check_eq("rst_wdata", bus.fifo_wdata_o,      32'd0);
        reset_n = 1'b1;
        tick(2);

        // 1) free-running consumer, base 0x0010, len 5
        clear_logs();
        d0 = done_cnt;
        start_burst(16'h0010, 16'd5);
        wait_done("t1_done", 200);
        check_eq("t1_busy_at_done", 32'(bus.busy_o), 32'd0);
        tick(1);
        check_eq("t1_done_one_cycle", 32'(bus.done_o), 32'd0);
        tick(3);
        check_eq("t1_n_req",   32'(addr_q.size()),  32'd5);
        check_eq("t1_n_write", 32'(wdata_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < wdata_q.size(); i++) begin
            check_eq("t1_data", wdata_q[i], 32'h10 + 32'(i));
        end
        check_eq("t1_done_cnt", 32'(done_cnt - d0), 32'd1);

        // 2) stalled consumer, len 8
        clear_logs();
        consumer_en = 1'b0;
        start_burst(16'h0200, 16'd8);
        tick(60);
        check_eq("t2_fifo_full",  32'(fifo_count),      32'd4);
        check_eq("t2_n_req_stall", 32'(addr_q.size()),  32'd4);
        check_eq("t2_n_wr_stall", 32'(wdata_q.size()),  32'd4);
        check_eq("t2_busy_stall", 32'(bus.busy_o),      32'd1);
        tick(20);
        check_eq("t2_n_req_hold", 32'(addr_q.size()),   32'd4);
        check_eq("t2_n_wr_hold",  32'(wdata_q.size()),  32'd4);
        consumer_en = 1'b1;
        wait_done("t2_done", 300);
        tick(3);
        check_eq("t2_n_write", 32'(wdata_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < wdata_q.size(); i++) begin
            check_eq("t2_data", wdata_q[i], 32'h200 + 32'(i));
        end
        check_eq("t2_max_inflight", 32'(max_inflight), 32'd2);
        check_eq("t2_overflow",     32'(overflow_cnt), 32'd0);

        // 3) zero-length burst
        clear_logs();
        d0 = done_cnt;
        start_burst(16'h0300, 16'd0);
        check_eq("t3_busy_in_done", 32'(bus.busy_o), 32'd1);
        check_eq("t3_done_early",   32'(bus.done_o), 32'd0);
        tick(1);
        check_eq("t3_done_pulse",   32'(bus.done_o), 32'd1);
        tick(4);
        check_eq("t3_n_req",   32'(addr_q.size()),    32'd0);
        check_eq("t3_n_write", 32'(wdata_q.size()),   32'd0);
        check_eq("t3_done_cnt", 32'(done_cnt - d0),   32'd1);

        // 4) address wrap
        clear_logs();
        start_burst(16'hFFFE, 16'd4);
        wait_done("t4_done", 200);
        tick(3);
        check_eq("t4_n_req", 32'(addr_q.size()), 32'd4);
        if (addr_q.size() == 4) begin
            check_eq("t4_addr0", addr_q[0], 32'h0000_FFFE);
            check_eq("t4_addr1", addr_q[1], 32'h0000_FFFF);
            check_eq("t4_addr2", addr_q[2], 32'h0000_0000);
            check_eq("t4_addr3", addr_q[3], 32'h0000_0001);
        end
        check_eq("t4_n_write", 32'(wdata_q.size()), 32'd4);
        if (wdata_q.size() == 4) begin
            check_eq("t4_data2", wdata_q[2], 32'h0000_0000);
        end

        // 5) abort after two issues; start while busy is ignored
        clear_logs();
        d0 = done_cnt;
        start_burst(16'h0400, 16'd6);
        wait_rd_pulses("t5_two_issues", 2, 50);
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i     = 1'b0;
        bus.base_addr_i = 16'h0700;
        bus.len_i       = 16'd3;
        bus.start_i     = 1'b1;
        check_eq("t5_busy_at_start", 32'(bus.busy_o), 32'd1);
        @(negedge clk);
        bus.start_i = 1'b0;
        wait_done("t5_done", 100);
        tick(10);
        check_eq("t5_n_req",   32'(addr_q.size()),  32'd2);
        check_eq("t5_n_write", 32'(wdata_q.size()), 32'd2);
        if (wdata_q.size() == 2) begin
            check_eq("t5_data0", wdata_q[0], 32'h400);
            check_eq("t5_data1", wdata_q[1], 32'h401);
        end
        check_eq("t5_done_cnt", 32'(done_cnt - d0), 32'd1);
        check_eq("t5_busy_end", 32'(bus.busy_o),     32'd0);

        // 6) reset with two requests outstanding
        clear_logs();
        start_burst(16'h0500, 16'd8);
        wait_rd_pulses("t6_two_issues", 2, 50);
        #2 reset_n = 1'b0;
        #1;
        check_eq("t6_rst_rd_en", 32'(bus.mem_rd_en_o), 32'd0);
        check_eq("t6_rst_addr",  32'(bus.mem_addr_o),  32'd0);
        check_eq("t6_rst_wren",  32'(bus.fifo_wren_o), 32'd0);
        check_eq("t6_rst_wdata", bus.fifo_wdata_o,     32'd0);
        check_eq("t6_rst_busy",  32'(bus.busy_o),      32'd0);
        check_eq("t6_rst_done",  32'(bus.done_o),      32'd0);
        tick(3);
        reset_n = 1'b1;
        na = addr_q.size();
        nw = wdata_q.size();
        tick(10);
        check_eq("t6_no_req_after",   32'(addr_q.size()),  32'(na));
        check_eq("t6_no_write_after", 32'(wdata_q.size()), 32'(nw));
        clear_logs();
        start_burst(16'h0600, 16'd3);
        wait_done("t6_done", 200);
        tick(3);
        check_eq("t6_n_write", 32'(wdata_q.size()), 32'd3);
        for (int i = 0; i < 3 && i < wdata_q.size(); i++) begin
            check_eq("t6_data", wdata_q[i], 32'h600 + 32'(i));
        end
        check_eq("t6_overflow", 32'(overflow_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
